// File: rtl/instr_mem_fetch.sv
// Instruction-side program memory with a serial byte loader and a registered fetch port.
// Optional build macro LOAD_CHECKSUM_EN adds a trailing XOR checksum byte to each load.
module instr_mem_fetch #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 256
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [ADDR_W-1:0]  Address_Instruction_Bus,
    input  logic               hab_sal,
    input  logic               i_ld_start,
    input  logic [7:0]         i_ld_byte,
    input  logic               i_ld_valid,
    output logic               o_ld_busy,
    output logic               o_ld_done,
    output logic               o_ld_err,
    output logic               o_run_en,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CNT,
        LOAD_DATA,
`ifdef LOAD_CHECKSUM_EN
        LOAD_CHK,
`endif
        RUN
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    n_words;
    logic [CNT_W-1:0]    loaded_cnt;
    logic [ADDR_W-1:0]   wr_ptr;
    logic                phase;
    logic [BYTE_W-1:0]   hi_byte;
    logic [INSTR_W-1:0]  mem [DEPTH];

    logic                mem_we_c;
    logic                last_word_c;
    logic [CNT_W-1:0]    n_from_byte_c;
    logic                addr_hit_c;

`ifdef LOAD_CHECKSUM_EN
    logic [BYTE_W-1:0]   chk_acc;
`else
    assign o_ld_err = 1'b0;
`endif

    // A count byte of zero encodes a full memory load
    assign n_from_byte_c = (i_ld_byte == '0) ? CNT_W'(DEPTH) : CNT_W'(i_ld_byte);
    assign last_word_c   = (CNT_W'(wr_ptr) + CNT_W'(1)) == n_words;
    assign addr_hit_c    = {1'b0, Address_Instruction_Bus} < loaded_cnt;
    assign mem_we_c      = i_Rst_n && (state == LOAD_DATA) && i_ld_valid && !i_ld_start && phase;

    // Storage has no reset; visibility is gated by loaded_cnt instead
    always_ff @(posedge i_Clk) begin
        if (mem_we_c) begin
            mem[wr_ptr] <= INSTR_W'({hi_byte, i_ld_byte});
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state         <= IDLE;
            n_words       <= '0;
            loaded_cnt    <= '0;
            wr_ptr        <= '0;
            phase         <= 1'b0;
            hi_byte       <= '0;
            o_ld_busy     <= 1'b0;
            o_ld_done     <= 1'b0;
            o_run_en      <= 1'b0;
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            chk_acc       <= '0;
            o_ld_err      <= 1'b0;
`endif
        end else begin
            o_ld_done     <= 1'b0;
            o_instr_valid <= 1'b0;
            // A start pulse overrides everything, including a byte in the same cycle
            if (i_ld_start) begin
                state      <= LOAD_CNT;
                loaded_cnt <= '0;
                o_ld_busy  <= 1'b1;
                o_run_en   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
                o_ld_err   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                    end
                    LOAD_CNT: begin
                        if (i_ld_valid) begin
                            n_words <= n_from_byte_c;
                            wr_ptr  <= '0;
                            phase   <= 1'b0;
                            state   <= LOAD_DATA;
`ifdef LOAD_CHECKSUM_EN
                            chk_acc <= i_ld_byte;
`endif
                        end
                    end
                    LOAD_DATA: begin
                        if (i_ld_valid) begin
`ifdef LOAD_CHECKSUM_EN
                            chk_acc <= chk_acc ^ i_ld_byte;
`endif
                            if (!phase) begin
                                hi_byte <= i_ld_byte;
                                phase   <= 1'b1;
                            end else begin
                                phase  <= 1'b0;
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                                if (last_word_c) begin
`ifdef LOAD_CHECKSUM_EN
                                    state      <= LOAD_CHK;
`else
                                    state      <= RUN;
                                    loaded_cnt <= n_words;
                                    o_ld_done  <= 1'b1;
                                    o_ld_busy  <= 1'b0;
                                    o_run_en   <= 1'b1;
`endif
                                end
                            end
                        end
                    end
`ifdef LOAD_CHECKSUM_EN
                    LOAD_CHK: begin
                        if (i_ld_valid) begin
                            o_ld_busy <= 1'b0;
                            if (i_ld_byte == chk_acc) begin
                                state      <= RUN;
                                loaded_cnt <= n_words;
                                o_ld_done  <= 1'b1;
                                o_run_en   <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                loaded_cnt <= '0;
                                o_ld_err   <= 1'b1;
                            end
                        end
                    end
`endif
                    RUN: begin
                        // Addresses past the loaded program fetch a NOP
                        o_instr       <= addr_hit_c ? mem[Address_Instruction_Bus] : '0;
                        o_instr_valid <= !hab_sal;
                    end
                    default: begin
                        state     <= IDLE;
                        o_ld_busy <= 1'b0;
                        o_run_en  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Self-checking bench for instr_mem_fetch: fixed vectors, corner sequences and random loads/fetches.
// Honours LOAD_CHECKSUM_EN the same way the design does.
module tb_instr_mem_fetch;

    logic        i_Clk = 1'b0;
    logic        i_Rst_n = 1'b0;
    logic [7:0]  Address_Instruction_Bus = '0;
    logic        hab_sal = 1'b0;
    logic        i_ld_start = 1'b0;
    logic [7:0]  i_ld_byte = '0;
    logic        i_ld_valid = 1'b0;
    logic        o_ld_busy;
    logic        o_ld_done;
    logic        o_ld_err;
    logic        o_run_en;
    logic [15:0] o_instr;
    logic        o_instr_valid;

    instr_mem_fetch dut (
        .i_Clk                   (i_Clk),
        .i_Rst_n                 (i_Rst_n),
        .Address_Instruction_Bus (Address_Instruction_Bus),
        .hab_sal                 (hab_sal),
        .i_ld_start              (i_ld_start),
        .i_ld_byte               (i_ld_byte),
        .i_ld_valid              (i_ld_valid),
        .o_ld_busy               (o_ld_busy),
        .o_ld_done               (o_ld_done),
        .o_ld_err                (o_ld_err),
        .o_run_en                (o_run_en),
        .o_instr                 (o_instr),
        .o_instr_valid           (o_instr_valid)
    );

    always #5 i_Clk = ~i_Clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] ref_mem [256];
    int          ref_cnt  = 0;
    logic [15:0] prog [256];
    logic [15:0] last_instr = '0;

    typedef struct {
        logic [7:0]  addr;
        logic        hab;
        logic [15:0] instr;
        logic        valid;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        for (int g = 0; g < gap; g++) step();
        i_ld_byte  = b;
        i_ld_valid = 1'b1;
        step();
        i_ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_ld_start = 1'b1;
        step();
        i_ld_start = 1'b0;
        ref_cnt    = 0;
    endtask

    // Loads prog[0..n-1]; n = 256 is sent as a count byte of zero
    task automatic load_prog(input int n, input int gap_max);
        logic [7:0] nb;
        logic [7:0] chk;
        nb = 8'(n);
        pulse_start();
        check("busy_after_start", o_ld_busy, 1);
        check("run_en_after_start", o_run_en, 0);
        send_byte(nb, gap_max);
        chk = nb;
        check("busy_in_load", o_ld_busy, 1);
        for (int i = 0; i < n; i++) begin
            send_byte(prog[i][15:8], gap_max);
            check("done_early", o_ld_done, 0);
            send_byte(prog[i][7:0], gap_max);
            chk = chk ^ prog[i][15:8] ^ prog[i][7:0];
        end
`ifdef LOAD_CHECKSUM_EN
        send_byte(chk, gap_max);
`endif
        check("load_done_pulse", o_ld_done, 1);
        check("load_run_en", o_run_en, 1);
        check("load_busy_clear", o_ld_busy, 0);
        for (int i = 0; i < n; i++) ref_mem[i] = prog[i];
        ref_cnt = n;
        step();
        check("done_one_cycle", o_ld_done, 0);
    endtask

    task automatic fetch(input logic [7:0] a, input logic h, input string tag);
        logic [15:0] exp;
        exp = (int'(a) < ref_cnt) ? ref_mem[a] : 16'h0000;
        Address_Instruction_Bus = a;
        hab_sal = h;
        step();
        hab_sal = 1'b0;
        check({tag, "_instr"}, o_instr, exp);
        check({tag, "_valid"}, o_instr_valid, !h);
        last_instr = exp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h00, 1'b0, 16'h1234, 1'b1};
        vecs[1] = '{8'h01, 1'b0, 16'hABCD, 1'b1};
        vecs[2] = '{8'h05, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{8'h01, 1'b1, 16'hABCD, 1'b0};
        vecs[4] = '{8'h00, 1'b0, 16'h1234, 1'b1};
        vecs[5] = '{8'hFF, 1'b0, 16'h0000, 1'b1};

        // Reset held for two edges
        i_Rst_n = 1'b0;
        step();
        step();
        check("rst_busy", o_ld_busy, 0);
        check("rst_done", o_ld_done, 0);
        check("rst_err", o_ld_err, 0);
        check("rst_run_en", o_run_en, 0);
        check("rst_instr", o_instr, 0);
        check("rst_valid", o_instr_valid, 0);
        i_Rst_n = 1'b1;
        step();

        // Bytes in IDLE must be ignored
        send_byte(8'h02, 0);
        check("idle_ignore_busy", o_ld_busy, 0);

        // Basic two-word program and fixed fetch vectors
        prog[0] = 16'h1234;
        prog[1] = 16'hABCD;
        load_prog(2, 0);
        for (int i = 0; i < 6; i++) begin
            Address_Instruction_Bus = vecs[i].addr;
            hab_sal = vecs[i].hab;
            step();
            check($sformatf("vec%0d_instr", i), o_instr, vecs[i].instr);
            check($sformatf("vec%0d_valid", i), o_instr_valid, vecs[i].valid);
        end
        hab_sal = 1'b0;
        last_instr = 16'h0000;

        // Restart from RUN, then again mid-load with start and valid together
        Address_Instruction_Bus = 8'h00;
        pulse_start();
        check("restart_run_en", o_run_en, 0);
        check("restart_valid", o_instr_valid, 0);
        check("restart_instr_hold", o_instr, last_instr);
        send_byte(8'h03, 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 0);
        i_ld_start = 1'b1;
        i_ld_valid = 1'b1;
        i_ld_byte  = 8'h55;
        step();
        i_ld_start = 1'b0;
        i_ld_valid = 1'b0;
        ref_cnt    = 0;
        check("start_wins_busy", o_ld_busy, 1);
        send_byte(8'h01, 0);
        send_byte(8'h00, 1);
        send_byte(8'h07, 1);
        check("reload_done", o_ld_done, 1);
        ref_mem[0] = 16'h0007;
        ref_cnt = 1;
        step();
        fetch(8'h00, 1'b0, "reload_a0");
        check("reload_a0_const", o_instr, 16'h0007);
        fetch(8'h01, 1'b0, "reload_a1_hidden");

        // Full 256-word load with wrap-around fetches
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        load_prog(256, 0);
        fetch(8'hFF, 1'b0, "full_ff");
        check("full_ff_last", o_instr, prog[255]);
        fetch(8'h00, 1'b0, "full_wrap0");
        check("full_wrap_first", o_instr, prog[0]);
        for (int i = 0; i < 100; i++) begin
            fetch(8'($urandom), ($urandom_range(0, 3) == 0), "full_rand");
        end

        // Random short loads with gaps; stale words above the count must read as NOP
        for (int it = 0; it < 4; it++) begin
            int n;
            n = int'($urandom_range(1, 40));
            for (int i = 0; i < n; i++) prog[i] = 16'($urandom);
            load_prog(n, 2);
            for (int i = 0; i < 60; i++) begin
                fetch(8'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0), "rand");
            end
        end

        // Reset in the middle of a load
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        i_Rst_n = 1'b0;
        step();
        i_Rst_n = 1'b1;
        ref_cnt = 0;
        check("midrst_busy", o_ld_busy, 0);
        check("midrst_run_en", o_run_en, 0);
        check("midrst_valid", o_instr_valid, 0);
        prog[0] = 16'h5A5A;
        load_prog(1, 0);
        fetch(8'h00, 1'b0, "midrst_a0");
        fetch(8'h02, 1'b0, "midrst_a2");

`ifdef LOAD_CHECKSUM_EN
        // Correct checksum enters RUN; a wrong one raises a sticky error
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h27, 0);
        check("chk_ok_done", o_ld_done, 1);
        check("chk_ok_run", o_run_en, 1);
        check("chk_ok_err", o_ld_err, 0);
        ref_mem[0] = 16'h1234;
        ref_cnt = 1;
        step();
        fetch(8'h00, 1'b0, "chk_ok_a0");
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h00, 0);
        check("chk_bad_err", o_ld_err, 1);
        check("chk_bad_done", o_ld_done, 0);
        check("chk_bad_run", o_run_en, 0);
        check("chk_bad_busy", o_ld_busy, 0);
        step();
        check("chk_err_sticky", o_ld_err, 1);
        check("chk_err_run", o_run_en, 0);
        pulse_start();
        check("chk_err_clear", o_ld_err, 0);
`else
        check("err_tied_low", o_ld_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
